// File: rtl/multi_debouncer.sv
// -----------------------------------------------------------------------------
// multi_debouncer
//
// N-channel push-button debouncer for the pedestrian and override inputs.
// Each channel runs a raw button through a two-flop synchroniser. A stability
// counter then filters bounce before the debounced level changes. Every
// accepted change produces a one-cycle rise or fall pulse. Rising edges are
// recorded in a sticky, maskable status register. That register drives a
// single level interrupt request.
//
// Parameters
//   N_CH        number of independent channels (1..32)
//   DELAY       cycles a synchronised input must hold a new value (>= 2)
//   LONG_DELAY  cycles of continuous high level that flag a long press
//               (> DELAY); only meaningful with the optional feature below
//
// Optional feature
//   DEBOUNCE_LONG_PRESS_EN  when defined, each channel gets a hold counter and
//                           long_press pulses once per press after LONG_DELAY
//                           cycles. When undefined, long_press is constant 0.
//
// Ports
//   clk         single clock, rising edge
//   rst         synchronous, active-high reset
//   btn         raw asynchronous button inputs            [N_CH]
//   btn_out     debounced levels                          [N_CH]
//   rise        one-cycle pulse on btn_out 0->1           [N_CH]
//   fall        one-cycle pulse on btn_out 1->0           [N_CH]
//   irq_mask    per-channel interrupt enable              [N_CH]
//   irq_clr     per-channel write-1-to-clear strobe       [N_CH]
//   irq_status  sticky rise-event flags                   [N_CH]
//   irq         OR of masked status bits
//   long_press  one-cycle long-press pulse                [N_CH]
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module multi_debouncer #(
  parameter int N_CH       = 4,
  parameter int DELAY      = 8,
  parameter int LONG_DELAY = 1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn,
  output logic [N_CH-1:0] btn_out,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  input  logic [N_CH-1:0] irq_mask,
  input  logic [N_CH-1:0] irq_clr,
  output logic [N_CH-1:0] irq_status,
  output logic            irq,
  output logic [N_CH-1:0] long_press
);

  localparam int            CW       = $clog2(DELAY + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DELAY - 1);

  // Catch illegal configurations at elaboration rather than in silicon.
  if (N_CH < 1 || N_CH > 32 || DELAY < 2 || LONG_DELAY <= DELAY) begin : g_bad_params
    $error("multi_debouncer: illegal parameter combination");
  end

  logic [N_CH-1:0] sync1_p0;
  logic [N_CH-1:0] s_p1;
  logic [CW-1:0]   cnt [N_CH];

  // Stage p0/p1: two-flop synchroniser for the asynchronous buttons
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_p0 <= '0;
      s_p1     <= '0;
    end else begin
      sync1_p0 <= btn;
      s_p1     <= sync1_p0;
    end
  end

  // Stage p2: stability filter. Any return to agreement restarts the count,
  // so only DELAY consecutive cycles of disagreement move btn_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_out <= '0;
      rise    <= '0;
      fall    <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        rise[i] <= 1'b0;
        fall[i] <= 1'b0;
        if (s_p1[i] == btn_out[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          btn_out[i] <= s_p1[i];
          cnt[i]     <= '0;
          rise[i]    <= s_p1[i];
          fall[i]    <= ~s_p1[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Stage p3: sticky status. A rise in the same cycle as a clear keeps the
  // bit set so no event is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_status <= '0;
    end else begin
      irq_status <= (irq_status & ~irq_clr) | rise;
    end
  end

  assign irq = |(irq_status & irq_mask);

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int            LW       = $clog2(LONG_DELAY + 1);
  localparam logic [LW-1:0] HOLD_MAX = LW'(LONG_DELAY);

  logic [LW-1:0] hold [N_CH];

  function automatic logic [LW-1:0] sat_inc(input logic [LW-1:0] v);
    return (v == HOLD_MAX) ? v : v + 1'b1;
  endfunction

  // Stage p3: hold counters. The pulse fires on the single edge where the
  // counter lands on HOLD_MAX; saturation keeps it from repeating.
  always_ff @(posedge clk) begin
    if (rst) begin
      long_press <= '0;
      for (int i = 0; i < N_CH; i++) begin
        hold[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        long_press[i] <= 1'b0;
        if (!btn_out[i]) begin
          hold[i] <= '0;
        end else begin
          hold[i]       <= sat_inc(hold[i]);
          long_press[i] <= (hold[i] == HOLD_MAX - 1'b1);
        end
      end
    end
  end
`else
  assign long_press = '0;
`endif

endmodule

// File: tb/tb_multi_debouncer.sv
`timescale 1ns/1ps

module tb_multi_debouncer;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn;
  logic [N-1:0] btn_out;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic [N-1:0] irq_mask;
  logic [N-1:0] irq_clr;
  logic [N-1:0] irq_status;
  logic         irq;
  logic [N-1:0] long_press;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multi_debouncer #(
    .N_CH       (N),
    .DELAY      (8),
    .LONG_DELAY (50)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn),
    .btn_out    (btn_out),
    .rise       (rise),
    .fall       (fall),
    .irq_mask   (irq_mask),
    .irq_clr    (irq_clr),
    .irq_status (irq_status),
    .irq        (irq),
    .long_press (long_press)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] exp_lp;

    // Reset with all buttons held high
    rst      = 1'b1;
    btn      = 4'hF;
    irq_mask = 4'h0;
    irq_clr  = 4'h0;
    tick(4);
    check("rst_btn_out", btn_out, 4'h0);
    check("rst_rise", rise, 4'h0);
    check("rst_fall", fall, 4'h0);
    check("rst_status", irq_status, 4'h0);
    check("rst_irq", {3'b000, irq}, 4'h0);
    check("rst_long", long_press, 4'h0);

    // Held-through-reset buttons become a fresh press
    rst = 1'b0;
    tick(9);
    check("t1_pre_out", btn_out, 4'h0);
    tick(1);
    check("t1_out", btn_out, 4'hF);
    check("t1_rise", rise, 4'hF);
    check("t1_fall", fall, 4'h0);
    check("t1_stat0", irq_status, 4'h0);
    tick(1);
    check("t1_rise_end", rise, 4'h0);
    check("t1_stat", irq_status, 4'hF);
    check("t1_irq_masked", {3'b000, irq}, 4'h0);
    btn     = 4'h0;
    irq_clr = 4'hF;
    tick(1);
    irq_clr = 4'h0;
    check("t1_clr", irq_status, 4'h0);
    tick(8);
    check("t1_pre_fall", btn_out, 4'hF);
    tick(1);
    check("t1_fall_out", btn_out, 4'h0);
    check("t1_fall", fall, 4'hF);
    tick(1);
    check("t1_fall_end", fall, 4'h0);
    check("t1_long", long_press, 4'h0);

    // Short glitch of 7 cycles on channel 0 is rejected
    btn = 4'h1;
    tick(7);
    btn = 4'h0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      check("t2_out", btn_out, 4'h0);
      check("t2_rise", rise, 4'h0);
      check("t2_stat", irq_status, 4'h0);
    end

    // Channel 1 press with interrupt enabled
    irq_mask = 4'h2;
    btn      = 4'h2;
    tick(9);
    check("t3_pre_out", btn_out, 4'h0);
    tick(1);
    check("t3_out", btn_out, 4'h2);
    check("t3_rise", rise, 4'h2);
    check("t3_irq0", {3'b000, irq}, 4'h0);
    tick(1);
    check("t3_rise_end", rise, 4'h0);
    check("t3_stat", irq_status, 4'h2);
    check("t3_irq", {3'b000, irq}, 4'h1);
    tick(9);
    btn = 4'h0;
    tick(9);
    check("t3_pre_fall", btn_out, 4'h2);
    check("t3_nofall", fall, 4'h0);
    tick(1);
    check("t3_fall_out", btn_out, 4'h0);
    check("t3_fall", fall, 4'h2);
    tick(1);
    check("t3_fall_end", fall, 4'h0);
    check("t3_irq_sticky", {3'b000, irq}, 4'h1);

    // Clear colliding with a new set: set wins; later lone clear works
    irq_clr = 4'h2;
    tick(1);
    irq_clr = 4'h0;
    check("t4_clr0", irq_status, 4'h0);
    check("t4_irq0", {3'b000, irq}, 4'h0);
    btn = 4'h2;
    tick(10);
    check("t4_rise", rise, 4'h2);
    irq_clr = 4'h2;
    tick(1);
    irq_clr = 4'h0;
    check("t4_set_wins", irq_status, 4'h2);
    check("t4_irq", {3'b000, irq}, 4'h1);
    tick(2);
    check("t4_hold", irq_status, 4'h2);
    irq_clr = 4'h2;
    tick(1);
    irq_clr = 4'h0;
    check("t4_clr", irq_status, 4'h0);
    check("t4_irq_off", {3'b000, irq}, 4'h0);
    btn = 4'h0;
    tick(12);
    check("t4_released", btn_out, 4'h0);

    // Reset in the middle of a channel 2 count
    btn = 4'h4;
    tick(7);
    rst = 1'b1;
    tick(1);
    check("t5_rst_out", btn_out, 4'h0);
    check("t5_rst_rise", rise, 4'h0);
    tick(1);
    check("t5_rst_rise2", rise, 4'h0);
    rst = 1'b0;
    tick(9);
    check("t5_pre_out", btn_out, 4'h0);
    check("t5_pre_rise", rise, 4'h0);
    tick(1);
    check("t5_out", btn_out, 4'h4);
    check("t5_rise", rise, 4'h4);
    tick(1);
    check("t5_stat", irq_status, 4'h4);
    check("t5_irq_masked", {3'b000, irq}, 4'h0);
    irq_mask = 4'h4;
    #1;
    check("t5_irq_unmasked", {3'b000, irq}, 4'h1);
    irq_mask = 4'h2;
    irq_clr  = 4'h4;
    tick(1);
    irq_clr = 4'h0;
    check("t5_clr", irq_status, 4'h0);
    btn = 4'h0;
    tick(12);
    check("t5_released", btn_out, 4'h0);

    // Long hold on channel 3
    btn = 4'h8;
    tick(10);
    check("t6_rise", rise, 4'h8);
    for (int k = 1; k <= 100; k++) begin
      tick(1);
`ifdef DEBOUNCE_LONG_PRESS_EN
      exp_lp = (k == 50) ? 4'h8 : 4'h0;
`else
      exp_lp = 4'h0;
`endif
      check("t6_long", long_press, exp_lp);
    end
    check("t6_out_held", btn_out, 4'h8);
    btn = 4'h0;
    tick(12);
    check("t6_released", btn_out, 4'h0);
    check("t6_long_end", long_press, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multi_debouncer.md
# multi_debouncer

Parametrised N-channel push-button debouncer for the traffic-light pedestrian and override inputs. Each channel synchronises a raw asynchronous button, filters bounce with a stability counter, and emits a debounced level plus one-cycle rise and fall pulses. Rising edges latch into a sticky, maskable status register that drives a single level interrupt request toward the PS interrupt controller.

## Interface
- `N_CH`, default 4: number of independent button channels, 1..32.
- `DELAY`, default 8: clock cycles a synchronised input must hold a new value before it is accepted, ≥2.
- `LONG_DELAY`, default 1000: cycles the debounced level must stay high to flag a long press, >`DELAY`. Used only with `DEBOUNCE_LONG_PRESS_EN`.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `btn` in `N_CH`: raw asynchronous button inputs.
- `btn_out` out `N_CH`: debounced levels.
- `rise` out `N_CH`: one-cycle pulse when `btn_out[i]` goes 0→1.
- `fall` out `N_CH`: one-cycle pulse when `btn_out[i]` goes 1→0.
- `irq_mask` in `N_CH`: per-channel interrupt enable.
- `irq_clr` in `N_CH`: per-channel write-1-to-clear strobe for `irq_status`.
- `irq_status` out `N_CH`: sticky rise-event flags.
- `irq` out 1: `|(irq_status & irq_mask)`.
- `long_press` out `N_CH`: one-cycle long-press pulse. Tied to 0 without the macro.

## Operation
- Per channel, a 2-flop synchroniser (`sync1` → `s`) resets to 0.
- Stability counter width is `$clog2(DELAY+1)`. Per edge:
  - If `s == btn_out`, the counter is set to 0.
  - Else if counter == `DELAY-1`, then `btn_out <= s`, the counter is set to 0, and `rise` or `fall` is asserted for that one cycle.
  - Else the counter increments.
- A mismatch shorter than `DELAY` consecutive cycles never changes `btn_out`. The counter restarts from 0 on every return to agreement.
- `irq_status[i]` sets on `rise[i]` and clears on `irq_clr[i]`. If set and clear occur in the same cycle, set wins so no event is lost.
- `irq` is combinational from registered `irq_status` and `irq_mask`.
- Channels are fully independent. Simultaneous events on several channels each produce their own pulses and status bits.
- Reset values: `btn_out`, `rise`, `fall`, `irq_status`, `irq`, `long_press`, the synchroniser and all counters are 0.
- A button held high through reset is reported as a fresh press after release, including a `rise` pulse.
- Reset asserted mid-count discards the partial count. No pulse is emitted.

## Timing
- Raw `btn` change captured at edge E0: `s` updates at E1.
- `btn_out` updates and `rise`/`fall` pulse at edge E0+`DELAY`+1. With `DELAY`=8, that is 9 cycles after capture.
- `irq_status` sets at E0+`DELAY`+2, one cycle after `rise`. `irq` follows in the same cycle.
- `irq_clr` takes effect at the next edge. `irq` deasserts in that same cycle if no other masked bit is set.
- `long_press[i]` pulses exactly `LONG_DELAY` cycles after the `rise[i]` edge.

## Configuration
- `DEBOUNCE_LONG_PRESS_EN` defined:
  - Each channel gets a hold counter of width `$clog2(LONG_DELAY+1)`. It is cleared while `btn_out[i]`=0 and increments while 1, saturating at `LONG_DELAY`.
  - `long_press[i]` pulses once when the counter reaches `LONG_DELAY`. It fires once per press, never repeating while held.
  - Release before `LONG_DELAY` produces no pulse.
- Macro undefined: no hold counters are instantiated, `long_press` is constant 0, and `LONG_DELAY` is ignored.

## Test plan
Settings: `N_CH`=4, `DELAY`=8, 10 ns clock.
- Reset with `btn`=4'hF held for 4 cycles, then release → all outputs 0 during reset. `btn_out`=4'hF 9 cycles after the first post-reset capture edge, `rise`=4'hF for one cycle.
- `btn[0]` high for 7 cycles, then low → `btn_out[0]`, `rise[0]` and `irq_status[0]` stay 0 throughout.
- `irq_mask`=4'h2, `btn[1]` held high 20 cycles, then low →
  - `btn_out[1]` rises 9 cycles after capture, with `rise[1]` for one cycle.
  - `irq_status[1]`=1 and `irq`=1 one cycle later.
  - `fall[1]` pulses 9 cycles after the release capture.
- `irq_clr[1]` pulsed in the same cycle as a new `rise[1]`-driven set → `irq_status[1]` remains 1. A later lone `irq_clr[1]` → status 0 and `irq`=0 on the next cycle.
- `rst` asserted when the channel 2 counter = 5 → counter 0 and no `rise[2]`. After release with `btn[2]` still high, a full 9-cycle filter applies again.
- With `DEBOUNCE_LONG_PRESS_EN` and `LONG_DELAY`=50, hold `btn[3]` for 100 cycles → a single `long_press[3]` pulse 50 cycles after `rise[3]`. Without the macro, `long_press`=0 throughout.
